// File: rtl/sw_scan_pkg.sv
// Shared state encoding and default parameters for the switch-scan controller.
package sw_scan_pkg;

    localparam int SW_SCAN_WIDTH    = 32;
    localparam int SW_SCAN_TICK_DIV = 50000;
    localparam int SW_SCAN_STABLE_N = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } sw_scan_state_e;

endpackage

// File: rtl/sw_tick_gen.sv
// Sample-tick prescaler: one-cycle o_tick every TICK_DIV enabled cycles.
// The count is held at zero while disabled so the first tick after enabling is a full period away.
module sw_tick_gen
    import sw_scan_pkg::*;
#(
    parameter int TICK_DIV = SW_SCAN_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          at_last;

    assign at_last = (count_q == LAST);
    assign o_tick  = i_en && at_last;

    always_comb begin
        // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (!i_en || at_last) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sw_scan_ctrl.sv
// Switch-scan controller: synchronize, sample on tick, debounce, latch change flags.
// Define SW_SCAN_IRQ_EN to drive o_irq from the pending flags; otherwise o_irq is tied low.
module sw_scan_ctrl
    import sw_scan_pkg::*;
#(
    parameter int WIDTH    = SW_SCAN_WIDTH,
    parameter int TICK_DIV = SW_SCAN_TICK_DIV,
    parameter int STABLE_N = SW_SCAN_STABLE_N
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_io_sw,
    input  logic             i_en,
    input  logic             i_ack_valid,
    input  logic [WIDTH-1:0] i_ack_mask,
    output logic [WIDTH-1:0] o_sw_val,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq,
    output logic             o_busy
);

    localparam int               CNT_W    = $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N);

    logic [WIDTH-1:0] meta_q, sync_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] sw_val_q, sw_val_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] set_mask, clr_mask;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    sw_scan_state_e   state_q, state_d;
    logic             tick;

    sw_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .o_tick  (tick)
    );

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (tick && (sync_q != sw_val_q)) begin
                    cand_d  = sync_q;
                    cnt_d   = CNT_ONE;
                    state_d = (STABLE_N == 1) ? COMMIT : SETTLE;
                end
            end
            SETTLE: begin
                if (!i_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (sync_q == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d = COMMIT;
                        end
                    end else if (sync_q == sw_val_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cand_d = sync_q;
                        cnt_d  = CNT_ONE;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A commit setting a bit overrides an acknowledge clearing it in the same cycle.
    always_comb begin
        set_mask  = (state_q == COMMIT) ? (cand_q ^ sw_val_q) : '0;
        clr_mask  = i_ack_valid ? i_ack_mask : '0;
        sw_val_d  = (state_q == COMMIT) ? cand_q : sw_val_q;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            sw_val_q  <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
        end else begin
            meta_q    <= i_io_sw;
            sync_q    <= meta_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            sw_val_q  <= sw_val_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    assign o_sw_val  = sw_val_q;
    assign o_pending = pending_q;
    assign o_busy    = (state_q == SETTLE) || (state_q == COMMIT);

`ifdef SW_SCAN_IRQ_EN
    assign o_irq = |pending_q;
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sw_scan_ctrl.sv
// Self-checking bench for sw_scan_ctrl: vector table with scoreboard, then multi-cycle corner sequences.
module tb_sw_scan_ctrl;

`ifdef SW_SCAN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sw = '0;
    logic        en = 1'b1;
    logic        ack_v = 1'b0;
    logic [31:0] ack_m = '0;
    logic [31:0] val, pend;
    logic        irq, busy;

    logic [31:0] sw8 = '0;
    logic        en8 = 1'b0;
    logic [31:0] val8, pend8;
    logic        irq8, busy8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sw_scan_ctrl #(.WIDTH(32), .TICK_DIV(1), .STABLE_N(4)) dut (
        .i_clk (clk), .i_reset (rst_n), .i_io_sw (sw), .i_en (en),
        .i_ack_valid (ack_v), .i_ack_mask (ack_m),
        .o_sw_val (val), .o_pending (pend), .o_irq (irq), .o_busy (busy)
    );

    sw_scan_ctrl #(.WIDTH(32), .TICK_DIV(8), .STABLE_N(4)) dut8 (
        .i_clk (clk), .i_reset (rst_n), .i_io_sw (sw8), .i_en (en8),
        .i_ack_valid (1'b0), .i_ack_mask (32'h0),
        .o_sw_val (val8), .o_pending (pend8), .o_irq (irq8), .o_busy (busy8)
    );

    typedef struct {
        logic [31:0] sw;
        logic [31:0] ack;
        logic        busy_mid;
        logic [31:0] val;
        logic [31:0] pend;
    } vec_t;

    typedef struct {
        logic [31:0] val;
        logic [31:0] pend;
        logic        irq;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sw    = '0;
        ack_v = 1'b0;
        ack_m = '0;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prev_val;
        exp_t        e;
        logic        saw_busy, bad_out;

        vecs[0] = '{32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0005, 32'h0000_0005};
        vecs[1] = '{32'h0000_0005, 32'h0000_0001, 1'b0, 32'h0000_0005, 32'h0000_0004};
        vecs[2] = '{32'h0000_00A5, 32'h0000_0004, 1'b1, 32'h0000_00A5, 32'h0000_00A0};
        vecs[3] = '{32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 32'h0000_00A5, 32'h0000_0000};
        vecs[4] = '{32'h8000_0001, 32'h0000_0000, 1'b1, 32'h8000_0001, 32'h8000_00A4};
        vecs[5] = '{32'h0000_0000, 32'h8000_00A4, 1'b1, 32'h0000_0000, 32'h8000_0001};
        vecs[6] = '{32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};

        // Reset state, both while asserted and after release
        #2;
        check("rst_val", val, 32'h0);
        check("rst_pend", pend, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        check("post_rst_val", val, 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        // Table phase: change lands at edge 7, still old value at edge 6
        prev_val = 32'h0;
        for (int i = 0; i < 8; i++) begin
            sw    = vecs[i].sw;
            ack_v = (vecs[i].ack != 32'h0);
            ack_m = vecs[i].ack;
            sb_q.push_back('{vecs[i].val, vecs[i].pend, IRQ_ON && (vecs[i].pend != 32'h0)});
            cycles(1);
            ack_v = 1'b0;
            ack_m = '0;
            cycles(5);
            check($sformatf("v%0d_busy_mid", i), 32'(busy), 32'(vecs[i].busy_mid));
            check($sformatf("v%0d_val_mid", i), val, prev_val);
            cycles(1);
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d_sb_empty", i), 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_val", i), val, e.val);
                check($sformatf("v%0d_pend", i), pend, e.pend);
                check($sformatf("v%0d_irq", i), 32'(irq), 32'(e.irq));
                check($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
            end
            prev_val = vecs[i].val;
            cycles(3);
        end

        // Glitch rejection: 0x1 for two cycles then back to 0
        do_reset();
        saw_busy = 1'b0;
        bad_out  = 1'b0;
        sw = 32'h1;
        cycles(2);
        sw = 32'h0;
        for (int k = 0; k < 12; k++) begin
            cycles(1);
            saw_busy = saw_busy | busy;
            bad_out  = bad_out | (val != 32'h0) | (pend != 32'h0);
        end
        check("glitch_busy_pulse", 32'(saw_busy), 32'h1);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_no_commit", 32'(bad_out), 32'h0);

        // Candidate restart: 0x1 for two samples, then 0x3 held
        sw = 32'h1;
        cycles(2);
        sw = 32'h3;
        cycles(6);
        check("restart_val_early", val, 32'h0);
        check("restart_busy_early", 32'(busy), 32'h1);
        cycles(1);
        check("restart_val", val, 32'h3);
        check("restart_pend", pend, 32'h3);
        check("restart_busy_end", 32'(busy), 32'h0);
        cycles(3);

        // Ack collides with a commit: bit 2 set wins, bit 0 still clears
        sw = 32'h7;
        cycles(6);
        check("coll_pend_before", pend, 32'h3);
        ack_v = 1'b1;
        ack_m = 32'h5;
        cycles(1);
        ack_v = 1'b0;
        ack_m = '0;
        check("coll_val", val, 32'h7);
        check("coll_pend", pend, 32'h6);
        check("coll_irq", 32'(irq), 32'(IRQ_ON));
        cycles(3);

        // Async reset during COMMIT clears outputs without a clock edge
        sw = 32'h0;
        cycles(6);
        check("arst_in_commit", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_val", val, 32'h0);
        check("arst_pend", pend, 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        cycles(1);
        rst_n = 1'b1;

        // Enable drop on the TICK_DIV=8 instance
        en8 = 1'b1;
        sw8 = 32'h1;
        cycles(20);
        check("en_mid_settle", 32'(busy8), 32'h1);
        en8 = 1'b0;
        cycles(1);
        check("en_drop_idle", 32'(busy8), 32'h0);
        bad_out = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycles(1);
            bad_out = bad_out | busy8 | (val8 != 32'h0) | (pend8 != 32'h0);
        end
        check("en_off_quiet", 32'(bad_out), 32'h0);
        en8 = 1'b1;
        cycles(32);
        check("en_re_val_early", val8, 32'h0);
        check("en_re_busy_early", 32'(busy8), 32'h1);
        cycles(1);
        check("en_re_val", val8, 32'h1);
        check("en_re_pend", pend8, 32'h1);
        check("en_re_irq", 32'(irq8), 32'(IRQ_ON));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
